dcache_wb_controller: RTL and testbench

Direct-mapped, write-back, write-allocate data cache. It is the responder to the CPU's MEM-stage load/store interface: read/write enables, address, store data, read data and a stall handshake. On a hit it serves the access in the same cycle. On a miss it raises BUSY_WAIT, runs a writeback/allocate sequence against a 128-bit block-oriented main memory, and then completes the access.

---
 rtl/dcache_pkg.sv | 24 ++
 rtl/dcache_wb_controller_if.sv | 32 +++
 rtl/load_store_align.sv | 51 +++++
 rtl/dcache_wb_controller.sv | 139 +++++++++++++
 tb/tb_dcache_wb_controller.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the write-back data cache.
// Holds FSM states, access encodings and line geometry.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int LINE_BYTES     = 16;
    localparam int WORDS_PER_LINE = 4;

endpackage

// File: rtl/dcache_wb_controller_if.sv
// CPU-side and memory-side bus of the data cache.
// slave = cache view, master = CPU/memory environment view.
interface dcache_wb_controller_if;

    logic [3:0]   READ_EN;
    logic [2:0]   WRITE_EN;
    logic [31:0]  ADDRESS;
    logic [31:0]  WRITE_DATA;
    logic [31:0]  READ_DATA;
    logic         BUSY_WAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    modport slave (
        input  READ_EN, WRITE_EN, ADDRESS, WRITE_DATA,
        input  MEM_READDATA, MEM_BUSYWAIT,
        output READ_DATA, BUSY_WAIT,
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport master (
        output READ_EN, WRITE_EN, ADDRESS, WRITE_DATA,
        output MEM_READDATA, MEM_BUSYWAIT,
        input  READ_DATA, BUSY_WAIT,
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

endinterface

// File: rtl/load_store_align.sv
// Byte/halfword/word lane steering for loads and stores.
// Purely combinational; no misalignment detection.
module load_store_align
    import dcache_pkg::*;
(
    input  logic [31:0] i_ld_word,
    input  logic [1:0]  i_ld_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_ld_data,
    input  logic [31:0] i_st_old,
    input  logic [31:0] i_st_data,
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_off,
    output logic [31:0] o_st_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Load: pick the lane and sign/zero extend it
    always_comb begin
        w_byte    = i_ld_word[{i_ld_off, 3'b000} +: 8];
        w_half    = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];
        o_ld_data = '0;
        case (i_funct3)
            F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
            F3_LW:   o_ld_data = i_ld_word;
            F3_LBU:  o_ld_data = {24'd0, w_byte};
            F3_LHU:  o_ld_data = {16'd0, w_half};
            default: o_ld_data = '0;
        endcase
    end

    // Store: merge the new lane(s) into the old word
    always_comb begin
        o_st_word = i_st_old;
        case (i_st_size)
            SZ_B: o_st_word[{i_st_off, 3'b000} +: 8] = i_st_data[7:0];
            SZ_H: begin
                if (i_st_off[1])
                    o_st_word[31:16] = i_st_data[15:0];
                else
                    o_st_word[15:0] = i_st_data[15:0];
            end
            SZ_W:    o_st_word = i_st_data;
            default: o_st_word = i_st_old;
        endcase
    end

endmodule

// File: rtl/dcache_wb_controller.sv
// Direct-mapped write-back write-allocate data cache.
// Hits serve in the same cycle; misses evict/fill a 128-bit line.
module dcache_wb_controller
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 3
) (
    input  logic                    CLK,
    input  logic                    RESET,
    dcache_wb_controller_if.slave   bus
);

    localparam int TAG_BITS = 32 - 4 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    logic [127:0]         r_data  [LINES];
    logic [TAG_BITS-1:0]  r_tag   [LINES];
    logic [LINES-1:0]     r_valid;
    logic [LINES-1:0]     r_dirty;
    state_t               r_state;
    state_t               w_next;

    logic [TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0] w_idx;
    logic [1:0]            w_word;
    logic [1:0]            w_off;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_req;
    logic                  w_hit;
    logic [127:0]          w_line;
    logic [31:0]           w_cur;
    logic [31:0]           w_ld_data;
    logic [31:0]           w_st_word;
    logic                  w_fill;
    logic                  w_store;

    assign w_tag  = bus.ADDRESS[31:4+INDEX_BITS];
    assign w_idx  = bus.ADDRESS[3+INDEX_BITS:4];
    assign w_word = bus.ADDRESS[3:2];
    assign w_off  = bus.ADDRESS[1:0];
    assign w_rd   = bus.READ_EN[3];
    assign w_wr   = bus.WRITE_EN[2];
    assign w_req  = w_rd | w_wr;
    assign w_line = r_data[w_idx];
    assign w_hit  = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_cur  = w_line[{w_word, 5'd0} +: 32];

    // Fill completes on the edge memory drops busy; size 11 stores nothing
    assign w_fill  = (r_state == ALLOCATE) & ~bus.MEM_BUSYWAIT;
    assign w_store = (r_state == IDLE) & w_wr & w_hit &
                     (bus.WRITE_EN[1:0] != 2'b11);

    load_store_align u_align (
        .i_ld_word (w_cur),
        .i_ld_off  (w_off),
        .i_funct3  (bus.READ_EN[2:0]),
        .o_ld_data (w_ld_data),
        .i_st_old  (w_cur),
        .i_st_data (bus.WRITE_DATA),
        .i_st_size (bus.WRITE_EN[1:0]),
        .i_st_off  (w_off),
        .o_st_word (w_st_word)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next state and bus outputs
    always_comb begin
        w_next            = r_state;
        bus.BUSY_WAIT     = 1'b0;
        bus.MEM_READ      = 1'b0;
        bus.MEM_WRITE     = 1'b0;
        bus.MEM_ADDRESS   = '0;
        bus.MEM_WRITEDATA = '0;
        bus.READ_DATA     = '0;
        case (r_state)
            IDLE: begin
                if (w_req && !w_hit) begin
                    bus.BUSY_WAIT = 1'b1;
                    if (r_valid[w_idx] && r_dirty[w_idx])
                        w_next = WRITEBACK;
                    else
                        w_next = ALLOCATE;
                end else if (w_rd && !w_wr && w_hit) begin
                    bus.READ_DATA = w_ld_data;
                end
            end
            WRITEBACK: begin
                bus.BUSY_WAIT     = 1'b1;
                bus.MEM_WRITE     = 1'b1;
                bus.MEM_ADDRESS   = {r_tag[w_idx], w_idx};
                bus.MEM_WRITEDATA = w_line;
                if (!bus.MEM_BUSYWAIT)
                    w_next = ALLOCATE;
            end
            ALLOCATE: begin
                bus.BUSY_WAIT   = 1'b1;
                bus.MEM_READ    = 1'b1;
                bus.MEM_ADDRESS = bus.ADDRESS[31:4];
                if (!bus.MEM_BUSYWAIT)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Valid/dirty bookkeeping; cleared by reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_fill) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
        end else if (w_store) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end

    // Tag/data arrays; untouched while reset is held
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (w_fill) begin
                r_data[w_idx] <= bus.MEM_READDATA;
                r_tag[w_idx]  <= w_tag;
            end else if (w_store) begin
                r_data[w_idx][{w_word, 5'd0} +: 32] <= w_st_word;
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb_controller.sv
// Directed bench for dcache_wb_controller with a latency-5 memory.
// Each check is an immediate assertion against hand-computed values.
module tb_dcache_wb_controller;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    dcache_wb_controller_if bus ();

    dcache_wb_controller #(.INDEX_BITS(3)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int MEM_L = 5;

    logic [127:0] mem [256];
    logic [255:0] mem_vld;
    logic [3:0]   mem_cnt;
    logic         mem_req;

    function automatic logic [127:0] init_blk(input logic [7:0] a);
        case (a)
            8'h04:   return 128'h0F0E0D0C_876543F0_DDCCBBAA_44332211;
            8'h44:   return 128'h11112222_33334444_55556666_77778888;
            default: return {4{24'd0, a}};
        endcase
    endfunction

    always_comb begin
        mem_req          = bus.MEM_READ | bus.MEM_WRITE;
        bus.MEM_BUSYWAIT = mem_req && (mem_cnt != 4'(MEM_L - 1));
        bus.MEM_READDATA = mem_vld[bus.MEM_ADDRESS[7:0]] ?
                           mem[bus.MEM_ADDRESS[7:0]] :
                           init_blk(bus.MEM_ADDRESS[7:0]);
    end

    // Memory: busy for L-1 cycles of a held request, then done
    always @(posedge clk) begin
        if (mem_req && bus.MEM_BUSYWAIT)
            mem_cnt <= mem_cnt + 4'd1;
        else
            mem_cnt <= 4'd0;
        if (bus.MEM_WRITE && !bus.MEM_BUSYWAIT) begin
            mem[bus.MEM_ADDRESS[7:0]]     <= bus.MEM_WRITEDATA;
            mem_vld[bus.MEM_ADDRESS[7:0]] <= 1'b1;
        end
    end

    // CPU must hold its request while stalled
    logic        pb_busy;
    logic        pb_rst;
    logic [70:0] pb_in;
    logic [70:0] cur_in;
    assign cur_in = {bus.READ_EN, bus.WRITE_EN, bus.ADDRESS, bus.WRITE_DATA};

    always @(negedge clk) begin
        if (pb_busy && pb_rst && rst_n) begin
            n_vec++;
            assert (cur_in === pb_in) else begin
                n_err++;
                $error("FAIL protocol observed=%0h expected=%0h", cur_in, pb_in);
            end
        end
        pb_busy = bus.BUSY_WAIT;
        pb_rst  = rst_n;
        pb_in   = cur_in;
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rd, input logic [2:0] wr,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk);
        #1;
        bus.READ_EN    = rd;
        bus.WRITE_EN   = wr;
        bus.ADDRESS    = addr;
        bus.WRITE_DATA = wd;
    endtask

    task automatic wait_done(output int n, output bit saw_w,
                             output logic [27:0] waddr,
                             output logic [127:0] wdata,
                             output bit saw_r,
                             output logic [27:0] raddr);
        n = 0;
        saw_w = 0;
        saw_r = 0;
        waddr = '0;
        wdata = '0;
        raddr = '0;
        @(negedge clk);
        while (bus.BUSY_WAIT === 1'b1 && n < 100) begin
            n++;
            if (bus.MEM_WRITE) begin
                saw_w = 1;
                waddr = bus.MEM_ADDRESS;
                wdata = bus.MEM_WRITEDATA;
            end
            if (bus.MEM_READ) begin
                saw_r = 1;
                raddr = bus.MEM_ADDRESS;
            end
            @(negedge clk);
        end
    endtask

    task automatic hit(input string tag, input logic [3:0] rd,
                       input logic [2:0] wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp);
        drive(rd, wr, addr, wd);
        @(negedge clk);
        chk({tag, "_busy"}, bus.BUSY_WAIT, 1'b0);
        chk({tag, "_data"}, bus.READ_DATA, exp);
    endtask

    int           n;
    bit           sw;
    bit           sr;
    logic [27:0]  wa;
    logic [27:0]  ra;
    logic [127:0] wd;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        mem_vld = '0;
        mem_cnt = '0;
        pb_busy = 1'b0;
        pb_rst  = 1'b0;
        pb_in   = '0;
        rst_n   = 1'b0;
        bus.READ_EN    = '0;
        bus.WRITE_EN   = '0;
        bus.ADDRESS    = '0;
        bus.WRITE_DATA = '0;

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", bus.BUSY_WAIT, 1'b0);
        chk("rst_mrd", bus.MEM_READ, 1'b0);
        chk("rst_mwr", bus.MEM_WRITE, 1'b0);
        chk("rst_rdata", bus.READ_DATA, 32'h0);
        chk("rst_maddr", bus.MEM_ADDRESS, 28'h0);
        chk("rst_mwdata", bus.MEM_WRITEDATA, 128'h0);

        // Clean miss, L=5: 6 stall cycles
        drive(4'b1010, 3'b000, 32'h40, 32'h0);
        wait_done(n, sw, wa, wd, sr, ra);
        chk("miss1_cycles", n, 6);
        chk("miss1_nowb", sw, 1'b0);
        chk("miss1_rd", sr, 1'b1);
        chk("miss1_raddr", ra, 28'h4);
        chk("miss1_data", bus.READ_DATA, 32'h44332211);

        hit("lb43", 4'b1000, 3'b000, 32'h43, 0, 32'h00000044);
        hit("lbu43", 4'b1100, 3'b000, 32'h43, 0, 32'h00000044);
        hit("lh42", 4'b1001, 3'b000, 32'h42, 0, 32'h00004433);
        hit("lb48", 4'b1000, 3'b000, 32'h48, 0, 32'hFFFFFFF0);
        hit("lbu48", 4'b1100, 3'b000, 32'h48, 0, 32'h000000F0);
        hit("lh4a", 4'b1001, 3'b000, 32'h4A, 0, 32'hFFFF8765);
        hit("lhu4b", 4'b1101, 3'b000, 32'h4B, 0, 32'h00008765);
        hit("lw4f", 4'b1010, 3'b000, 32'h4F, 0, 32'h0F0E0D0C);
        hit("resv", 4'b1011, 3'b000, 32'h40, 0, 32'h0);

        hit("sb41", 4'b0000, 3'b100, 32'h41, 32'h123456AB, 32'h0);
        hit("lw40", 4'b1010, 3'b000, 32'h40, 0, 32'h4433AB11);

        // Dirty miss, L=5: 11 stall cycles
        drive(4'b1010, 3'b000, 32'h440, 32'h0);
        wait_done(n, sw, wa, wd, sr, ra);
        chk("miss2_cycles", n, 11);
        chk("miss2_wb", sw, 1'b1);
        chk("miss2_waddr", wa, 28'h4);
        chk("miss2_wdata", wd,
            128'h0F0E0D0C_876543F0_DDCCBBAA_4433AB11);
        chk("miss2_rd", sr, 1'b1);
        chk("miss2_raddr", ra, 28'h44);
        chk("miss2_data", bus.READ_DATA, 32'h77778888);
        chk("miss2_mem", mem[8'h04][31:0], 32'h4433AB11);

        // Reset while allocating aborts the fill
        drive(4'b1010, 3'b000, 32'h840, 32'h0);
        @(negedge clk);
        chk("rmid_idle_busy", bus.BUSY_WAIT, 1'b1);
        @(negedge clk);
        chk("rmid_alloc", bus.MEM_READ, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.READ_EN = '0;
        bus.ADDRESS = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rmid_mrd", bus.MEM_READ, 1'b0);
        chk("rmid_busy", bus.BUSY_WAIT, 1'b0);

        drive(4'b1010, 3'b000, 32'h440, 32'h0);
        wait_done(n, sw, wa, wd, sr, ra);
        chk("miss3_cycles", n, 6);
        chk("miss3_nowb", sw, 1'b0);
        chk("miss3_raddr", ra, 28'h44);
        chk("miss3_data", bus.READ_DATA, 32'h77778888);

        // Load+store together: store wins, no read data
        hit("both", 4'b1010, 3'b110, 32'h444, 32'hCAFEBABE, 32'h0);
        hit("lw444a", 4'b1010, 3'b000, 32'h444, 0, 32'hCAFEBABE);
        hit("sh446", 4'b0000, 3'b101, 32'h447, 32'hFFFF1234, 32'h0);
        hit("lw444b", 4'b1010, 3'b000, 32'h444, 0, 32'h1234BABE);
        hit("snop", 4'b0000, 3'b111, 32'h444, 32'hFFFFFFFF, 32'h0);
        hit("lw444c", 4'b1010, 3'b000, 32'h444, 0, 32'h1234BABE);
        hit("noreq", 4'b0000, 3'b000, 32'h444, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
